capture_controller: RTL and testbench

Sample-buffer write/read sequencer on the consumer side of the trigger path. It arms a capture, fills the pre-trigger window, and only then drives ENABLE_TRIGG to the synchronization logic. It accepts the returned trigger event, counts post-trigger samples and stops writing. It then replays the captured window to the host interface in chronological order.

---
 rtl/capture_controller.sv | 168 ++++++++++++++++
 tb/tb_capture_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// Capture sequencer: arms, fills the pre-trigger window, waits for a trigger, fills the post window, then replays it.
// Optional auto-trigger timeout is compiled in with `define CAPTURE_AUTO_TRIG_EN (adds the AUTO_TO port).
module capture_controller #(
  parameter int ADDR_W = 12,
  parameter int TO_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLK_EN,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] PRE_LEN,
  input  logic [ADDR_W-1:0] POST_LEN,
  input  logic              TRIG_EV,
`ifdef CAPTURE_AUTO_TRIG_EN
  input  logic [TO_W-1:0]   AUTO_TO,
`endif
  output logic              ENABLE_TRIGG,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  input  logic              RD_NEXT,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic              AUTO_FLAG
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_reg, state_next;
  logic              enable_trigg_reg;
  logic [ADDR_W-1:0] wr_addr_reg, trig_addr_reg, rd_addr_reg;
  logic [ADDR_W:0]   pre_cnt_reg, post_cnt_reg, rd_cnt_reg;
  logic [ADDR_W:0]   pre_eff_reg, post_eff_reg;
  logic [ADDR_W:0]   post_eff_calc, pre_room, pre_eff_calc;
  logic [ADDR_W-1:0] done_base;
  logic              busy, start_take, real_hit, auto_hit, trig_take, rd_last, enter_done;

  // Window sizes: at least one post sample, and pre+post never exceeds the memory.
  assign post_eff_calc = (POST_LEN == '0) ? CNT_ONE : {1'b0, POST_LEN};
  assign pre_room      = DEPTH - post_eff_calc;
  assign pre_eff_calc  = ({1'b0, PRE_LEN} < pre_room) ? {1'b0, PRE_LEN} : pre_room;

  assign busy       = (state_reg == S_PRE) || (state_reg == S_ARMED) || (state_reg == S_POST);
  assign start_take = START && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign real_hit   = (state_reg == S_ARMED) && CLK_EN && TRIG_EV;
  assign trig_take  = real_hit || auto_hit;
  assign rd_last    = (state_reg == S_DONE) && (rd_cnt_reg == pre_eff_reg + post_eff_reg);
  assign done_base  = (state_reg == S_ARMED) ? wr_addr_reg : trig_addr_reg;
  assign enter_done = (state_next == S_DONE) && (state_reg != S_DONE);

  always_comb begin
    state_next = state_reg;
    if (ABORT) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (START) state_next = (pre_eff_calc == '0) ? S_ARMED : S_PRE;
        S_PRE:   if (CLK_EN && (pre_cnt_reg + CNT_ONE == pre_eff_reg)) state_next = S_ARMED;
        S_ARMED: if (trig_take) state_next = (post_eff_reg == CNT_ONE) ? S_DONE : S_POST;
        S_POST:  if (CLK_EN && (post_cnt_reg + CNT_ONE == post_eff_reg)) state_next = S_DONE;
        S_DONE: begin
          if (START)                state_next = (pre_eff_calc == '0) ? S_ARMED : S_PRE;
          else if (RD_NEXT && rd_last) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg        <= S_IDLE;
      enable_trigg_reg <= 1'b0;
      wr_addr_reg      <= '0;
      trig_addr_reg    <= '0;
      rd_addr_reg      <= '0;
      rd_cnt_reg       <= '0;
      pre_cnt_reg      <= '0;
      post_cnt_reg     <= '0;
      pre_eff_reg      <= '0;
      post_eff_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      enable_trigg_reg <= (state_next == S_ARMED);
      if (ABORT) begin
        wr_addr_reg  <= '0;
        rd_addr_reg  <= '0;
        rd_cnt_reg   <= '0;
        pre_cnt_reg  <= '0;
        post_cnt_reg <= '0;
      end else begin
        if (start_take) begin
          wr_addr_reg  <= '0;
          pre_cnt_reg  <= '0;
          post_cnt_reg <= '0;
          rd_cnt_reg   <= '0;
          pre_eff_reg  <= pre_eff_calc;
          post_eff_reg <= post_eff_calc;
        end
        if (busy && CLK_EN) wr_addr_reg <= wr_addr_reg + ADR_ONE;
        if ((state_reg == S_PRE) && CLK_EN) pre_cnt_reg <= pre_cnt_reg + CNT_ONE;
        if (trig_take) begin
          trig_addr_reg <= wr_addr_reg;
          post_cnt_reg  <= CNT_ONE;
        end
        if ((state_reg == S_POST) && CLK_EN) post_cnt_reg <= post_cnt_reg + CNT_ONE;
        // Readout starts pre_eff samples before the trigger, i.e. at the oldest kept sample.
        if (enter_done) begin
          rd_addr_reg <= done_base - pre_eff_reg[ADDR_W-1:0];
          rd_cnt_reg  <= CNT_ONE;
        end else if ((state_reg == S_DONE) && RD_NEXT && !rd_last && !START) begin
          rd_addr_reg <= rd_addr_reg + ADR_ONE;
          rd_cnt_reg  <= rd_cnt_reg + CNT_ONE;
        end
      end
    end
  end

`ifdef CAPTURE_AUTO_TRIG_EN
  logic [TO_W-1:0] auto_cnt_reg;
  logic            auto_flag_reg;

  // A real trigger on the same sample takes precedence, hence the !TRIG_EV term.
  assign auto_hit = (state_reg == S_ARMED) && CLK_EN && !TRIG_EV && (AUTO_TO != '0) &&
                    (auto_cnt_reg + TO_W'(1) == AUTO_TO);

  always_ff @(posedge CLK) begin
    if (RST) begin
      auto_cnt_reg  <= '0;
      auto_flag_reg <= 1'b0;
    end else if (ABORT) begin
      auto_cnt_reg <= '0;
    end else if (start_take) begin
      auto_cnt_reg  <= '0;
      auto_flag_reg <= 1'b0;
    end else if ((state_reg == S_ARMED) && CLK_EN) begin
      if (trig_take) auto_flag_reg <= auto_hit;
      else           auto_cnt_reg  <= auto_cnt_reg + TO_W'(1);
    end
  end

  assign AUTO_FLAG = auto_flag_reg;
`else
  assign auto_hit  = 1'b0;
  assign AUTO_FLAG = 1'b0;
`endif

  assign ENABLE_TRIGG = enable_trigg_reg;
  assign WR_EN        = busy && CLK_EN;
  assign WR_ADDR      = wr_addr_reg;
  assign TRIG_ADDR    = trig_addr_reg;
  assign RD_ADDR      = rd_addr_reg;
  assign RD_LAST      = rd_last;
  assign BUSY         = busy;
  assign DONE         = (state_reg == S_DONE);

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: sample-count reference model, randomized strobes/noise, directed boundary cases.
module tb_capture_controller;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, clk_en, start, abort, trig_ev, rd_next;
  logic [AW-1:0] pre_len, post_len;
  logic [15:0]   auto_to;
  logic          enable_trigg, wr_en, rd_last, busy, done, auto_flag;
  logic [AW-1:0] wr_addr, trig_addr, rd_addr;

  int checks = 0;
  int failures = 0;
  int last_trig = 0;

  capture_controller #(.ADDR_W(AW), .TO_W(16)) dut (
    .CLK(clk), .RST(rst), .CLK_EN(clk_en), .START(start), .ABORT(abort),
    .PRE_LEN(pre_len), .POST_LEN(post_len), .TRIG_EV(trig_ev),
`ifdef CAPTURE_AUTO_TRIG_EN
    .AUTO_TO(auto_to),
`endif
    .ENABLE_TRIGG(enable_trigg), .WR_EN(wr_en), .WR_ADDR(wr_addr), .TRIG_ADDR(trig_addr),
    .RD_NEXT(rd_next), .RD_ADDR(rd_addr), .RD_LAST(rd_last), .BUSY(busy), .DONE(done),
    .AUTO_FLAG(auto_flag)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; abort = 1'b0; trig_ev = 1'b0; rd_next = 1'b0;
    pre_len = '0; post_len = '0; auto_to = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({enable_trigg, wr_en, busy, done, rd_last, auto_flag} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000", {enable_trigg, wr_en, busy, done, rd_last, auto_flag});
    end
    checks++; if ({wr_addr, trig_addr, rd_addr} !== 12'h000) begin
      failures++; $display("FAIL reset_addrs: got %h expected 000", {wr_addr, trig_addr, rd_addr});
    end
    rst = 1'b0; clk_en = 1'b0;
    $display("reset: checked outputs after reset");
  endtask

  // trig_mode: 0 trigger on sample pre_eff+k_off, 1 TRIG_EV held high, 2 no trigger (auto timeout)
  // en_mode: 0 random strobe, 1 strobe every second cycle. read_n < 0 reads the whole window.
  task automatic run_capture(input int pre, input int post, input int k_off, input int en_mode,
                             input int trig_mode, input int read_n, input string name);
    int post_eff, pre_eff, total, k, n_written, s, cyc, i, n_read;
    logic exp_auto;
    post_eff = (post == 0) ? 1 : post;
    pre_eff  = (pre < DEPTH - post_eff) ? pre : DEPTH - post_eff;
    total    = pre_eff + post_eff;
    k        = (trig_mode == 1) ? pre_eff : (trig_mode == 2) ? pre_eff + int'(auto_to) - 1 : pre_eff + k_off;
    n_written = k + post_eff;
    exp_auto = (trig_mode == 2);
    n_read   = (read_n < 0) ? total : read_n;

    @(negedge clk);
    pre_len = AW'(pre); post_len = AW'(post); start = 1'b1; clk_en = 1'b0; trig_ev = 1'b0; rd_next = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0; #1;
    checks++; if ({busy, done, auto_flag} !== 3'b100 || wr_addr !== '0) begin
      failures++; $display("FAIL %s_start: busy/done/auto=%b wr_addr=%0d expected 100 and 0", name, {busy, done, auto_flag}, wr_addr);
    end
    s = 0; cyc = 0;
    while (s < n_written && cyc < 1000) begin
      clk_en  = (en_mode == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 99) < 60);
      if (trig_mode == 1)                 trig_ev = 1'b1;
      else if (trig_mode == 2)            trig_ev = 1'b0;
      else if (s == k && clk_en)          trig_ev = 1'b1;
      else if (s >= pre_eff && clk_en)    trig_ev = 1'b0;
      else                                trig_ev = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 19) == 0);
      rd_next = 1'($urandom_range(0, 1));
      #1;
      checks++; if (wr_en !== clk_en || wr_addr !== AW'(s % DEPTH)) begin
        failures++; $display("FAIL %s_write: sample %0d wr_en=%b wr_addr=%0d expected %b %0d", name, s, wr_en, wr_addr, clk_en, s % DEPTH);
      end
      checks++; if (enable_trigg !== (s >= pre_eff && s <= k) || busy !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL %s_phase: sample %0d en_trig=%b busy=%b done=%b expected %b 1 0", name, s, enable_trigg, busy, done, (s >= pre_eff && s <= k));
      end
      @(posedge clk);
      if (clk_en) s++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (cyc >= 1000) begin
      checks++; failures++; $display("FAIL %s_timeout: wrote %0d samples expected %0d", name, s, n_written);
      return;
    end
    i = 0; cyc = 0;
    while (i < n_read && cyc < 1000) begin
      rd_next = ($urandom_range(0, 99) < 70);
      clk_en  = 1'($urandom_range(0, 1));
      trig_ev = 1'($urandom_range(0, 1));
      #1;
      checks++; if ({done, busy, wr_en} !== 3'b100 || trig_addr !== AW'(k % DEPTH) || auto_flag !== exp_auto) begin
        failures++; $display("FAIL %s_done: done/busy/wr_en=%b trig_addr=%0d auto=%b expected 100 %0d %b", name, {done, busy, wr_en}, trig_addr, auto_flag, k % DEPTH, exp_auto);
      end
      checks++; if (rd_addr !== AW'((k - pre_eff + i) % DEPTH) || rd_last !== (i == total - 1)) begin
        failures++; $display("FAIL %s_read: index %0d rd_addr=%0d rd_last=%b expected %0d %b", name, i, rd_addr, rd_last, (k - pre_eff + i) % DEPTH, (i == total - 1));
      end
      @(posedge clk);
      if (rd_next) i++;
      cyc++;
      @(negedge clk);
    end
    rd_next = 1'b0;
    if (read_n < 0) begin
      #1;
      checks++; if ({done, busy, rd_last} !== 3'b000) begin
        failures++; $display("FAIL %s_end: done/busy/rd_last=%b expected 000", name, {done, busy, rd_last});
      end
    end
    last_trig = k % DEPTH;
    $display("%s: pre_eff=%0d post_eff=%0d trig_addr=%0d read %0d of %0d", name, pre_eff, post_eff, k % DEPTH, i, total);
  endtask

  task automatic test_abort;
    logic [AW-1:0] exp_trig;
    exp_trig = AW'(last_trig);
    @(negedge clk); pre_len = 4'd2; post_len = 4'd3; start = 1'b1; clk_en = 1'b0; trig_ev = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0; clk_en = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    clk_en = 1'b1; trig_ev = 1'b1; abort = 1'b1; #1;
    checks++; if (enable_trigg !== 1'b1) begin
      failures++; $display("FAIL abort_armed: enable_trigg=%b expected 1", enable_trigg);
    end
    @(posedge clk);
    @(negedge clk); abort = 1'b0; trig_ev = 1'b0; clk_en = 1'b1; #1;
    checks++; if ({busy, enable_trigg, wr_en, done} !== 4'b0000 || wr_addr !== '0) begin
      failures++; $display("FAIL abort_idle: busy/en/wr_en/done=%b wr_addr=%0d expected 0000 0", {busy, enable_trigg, wr_en, done}, wr_addr);
    end
    checks++; if (trig_addr !== exp_trig) begin
      failures++; $display("FAIL abort_trig_addr: got %0d expected %0d", trig_addr, exp_trig);
    end
    // reset mid-capture also clears the trigger address
    start = 1'b1; clk_en = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0; clk_en = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1; @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({busy, done, auto_flag} !== 3'b000 || trig_addr !== '0) begin
      failures++; $display("FAIL reset_mid: busy/done/auto=%b trig_addr=%0d expected 000 0", {busy, done, auto_flag}, trig_addr);
    end
    clk_en = 1'b0; last_trig = 0;
    $display("abort: abort and mid-capture reset checked");
  endtask

  task automatic test_rearm;
    run_capture(15, 15, 3, 0, 0, 2, "partial");
    run_capture(0, 1, int'($urandom_range(0, 6)), 0, 0, -1, "rearm_min");
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++)
      run_capture(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), 0, 0, -1, "random");
  endtask

`ifdef CAPTURE_AUTO_TRIG_EN
  task automatic test_auto;
    auto_to = 16'd10;
    run_capture(2, 3, 0, 0, 2, -1, "auto_timeout");
    run_capture(2, 3, 9, 0, 0, -1, "auto_real");
    auto_to = 16'd0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    run_capture(3, 4, 2, 1, 0, -1, "basic");
    test_abort();
    run_capture(2, 0, 0, 0, 1, -1, "trig_held");
    run_capture(14, 5, 8, 0, 0, -1, "wrap");
    test_rearm();
    test_random();
`ifdef CAPTURE_AUTO_TRIG_EN
    test_auto();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
